// File: rtl/csr_unit.sv
// Machine-mode CSR file with trap entry, mret return and a registered one-cycle fetch redirect.
// Optional 64-bit mcycle counter at 0xB00/0xB80 is built when CSR_MCYCLE_EN is defined.
module csr_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cause_set,
    input  logic        mepc_set,
    input  logic        I_or_E,
    input  logic [3:0]  cause_in,
    input  logic [29:0] exception_intr_address_in,
    input  logic        is_mret,
    input  logic [31:0] irq_pc,
    input  logic        ext_irq,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic        Take_trap,
    output logic        redirect,
    output logic [31:0] redirect_pc
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;

    logic        mie_q, mpie_q, meie_q, meip_q;
    logic [29:0] mtvec_q, mepc_q;
    logic [31:0] mscratch_q, mcause_q;
    logic        redirect_q;
    logic [31:0] redirect_pc_q;
`ifdef CSR_MCYCLE_EN
    logic [63:0] mcycle_q;
`endif

    logic [31:0] rd_val, wr_val;
    logic        implemented, take_trap, do_trap, do_mret, do_wr;
    logic        unused_bits;

    // I_or_E is implied by which path (cause_set vs Take_trap) raised the trap.
    assign unused_bits = ^{irq_pc[1:0], I_or_E};

    always_comb begin
        rd_val      = '0;
        implemented = 1'b1;
        case (csr_addr)
            A_MSTATUS:  rd_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            A_MIE:      rd_val = {20'b0, meie_q, 11'b0};
            A_MTVEC:    rd_val = {mtvec_q, 2'b00};
            A_MSCRATCH: rd_val = mscratch_q;
            A_MEPC:     rd_val = {mepc_q, 2'b00};
            A_MCAUSE:   rd_val = mcause_q;
            A_MIP:      rd_val = {20'b0, meip_q, 11'b0};
`ifdef CSR_MCYCLE_EN
            A_MCYCLE:   rd_val = mcycle_q[31:0];
            A_MCYCLEH:  rd_val = mcycle_q[63:32];
`endif
            default:    implemented = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op)
            2'b01:   wr_val = csr_wdata;
            2'b10:   wr_val = rd_val | csr_wdata;
            2'b11:   wr_val = rd_val & ~csr_wdata;
            default: wr_val = rd_val;
        endcase
    end

    // Exception beats interrupt beats mret beats CSR write; only one lands per cycle.
    assign take_trap = mie_q & meie_q & meip_q & ~cause_set & ~redirect_q;
    assign do_trap   = cause_set | take_trap;
    assign do_mret   = is_mret & ~do_trap;
    assign do_wr     = csr_en & (csr_op != 2'b00) & implemented & ~do_trap & ~is_mret;

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            meie_q        <= 1'b0;
            meip_q        <= 1'b0;
            mtvec_q       <= RESET_MTVEC[31:2];
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            meip_q     <= ext_irq;
            redirect_q <= 1'b0;
            if (do_trap) begin
                mpie_q        <= mie_q;
                mie_q         <= 1'b0;
                redirect_q    <= 1'b1;
                redirect_pc_q <= {mtvec_q, 2'b00};
                if (cause_set) begin
                    mcause_q <= {28'b0, cause_in};
                    if (mepc_set)
                        mepc_q <= exception_intr_address_in;
                end else begin
                    mcause_q <= 32'h8000_000B;
                    mepc_q   <= irq_pc[31:2];
                end
            end else if (do_mret) begin
                mie_q         <= mpie_q;
                mpie_q        <= 1'b1;
                redirect_q    <= 1'b1;
                redirect_pc_q <= {mepc_q, 2'b00};
            end else if (do_wr) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        mie_q  <= wr_val[3];
                        mpie_q <= wr_val[7];
                    end
                    A_MIE:      meie_q     <= wr_val[11];
                    A_MTVEC:    mtvec_q    <= wr_val[31:2];
                    A_MSCRATCH: mscratch_q <= wr_val;
                    A_MEPC:     mepc_q     <= wr_val[31:2];
                    A_MCAUSE:   mcause_q   <= wr_val;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_MCYCLE_EN
    always_ff @(posedge clk) begin
        if (rst)
            mcycle_q <= '0;
        else if (do_wr && csr_addr == A_MCYCLE)
            mcycle_q[31:0] <= wr_val;
        else if (do_wr && csr_addr == A_MCYCLEH)
            mcycle_q[63:32] <= wr_val;
        else
            mcycle_q <= mcycle_q + 64'd1;
    end
`endif

    assign csr_rdata   = rd_val;
    assign csr_illegal = csr_en & ~implemented;
    assign Take_trap   = take_trap;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
endmodule

// File: tb/tb_csr_unit.sv
// Directed vector table for the trap/mret/CSR corner cases, then randomized cycles against a word/mask CSR model.
module tb_csr_unit;
    logic        clk = 1'b0;
    logic        rst, cause_set, mepc_set, I_or_E, is_mret, ext_irq, csr_en;
    logic [3:0]  cause_in;
    logic [29:0] exception_intr_address_in;
    logic [31:0] irq_pc, csr_wdata;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata, redirect_pc;
    logic        csr_illegal, Take_trap, redirect;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    csr_unit dut (
        .clk(clk), .rst(rst), .cause_set(cause_set), .mepc_set(mepc_set), .I_or_E(I_or_E),
        .cause_in(cause_in), .exception_intr_address_in(exception_intr_address_in),
        .is_mret(is_mret), .irq_pc(irq_pc), .ext_irq(ext_irq), .csr_en(csr_en),
        .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .Take_trap(Take_trap),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic        rst, cs, mset;
        logic [3:0]  cause;
        logic [29:0] eaddr;
        logic        mret;
        logic [31:0] irq;
        logic        ext, en;
        logic [1:0]  op;
        logic [11:0] caddr;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] e_rd;
        logic        e_ill, e_tt, e_red;
        logic [31:0] e_rpc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic cs, input logic ms, input logic [3:0] ca,
                                input logic [29:0] ea, input logic mr, input logic [31:0] ip,
                                input logic ex, input logic en, input logic [1:0] op,
                                input logic [11:0] ad, input logic [31:0] wd, input logic ck,
                                input logic [31:0] erd, input logic eil, input logic ett,
                                input logic ere, input logic [31:0] erp);
        vec_t v;
        v.rst = r; v.cs = cs; v.mset = ms; v.cause = ca; v.eaddr = ea; v.mret = mr;
        v.irq = ip; v.ext = ex; v.en = en; v.op = op; v.caddr = ad; v.wd = wd; v.chk = ck;
        v.e_rd = erd; v.e_ill = eil; v.e_tt = ett; v.e_red = ere; v.e_rpc = erp;
        return v;
    endfunction

    // Reference model: each CSR as a whole word plus a writable-bit mask.
    logic [31:0] m_ms, m_mie, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause, m_rpc;
    logic        m_red;
    logic [63:0] m_cyc;

    task automatic mread(input logic [11:0] a, output logic ok, output logic [31:0] v);
        ok = 1'b1;
        case (a)
            12'h300: v = m_ms;
            12'h304: v = m_mie;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h344: v = m_mip;
`ifdef CSR_MCYCLE_EN
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
`endif
            default: begin ok = 1'b0; v = 32'h0; end
        endcase
    endtask

    function automatic logic [31:0] wmask(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_0088;
            12'h304: return 32'h0000_0800;
            12'h305, 12'h341: return 32'hFFFF_FFFC;
            12'h340, 12'h342: return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_tt();
        return m_ms[3] & m_mie[11] & m_mip[11] & ~cause_set & ~m_red;
    endfunction

    task automatic model_step();
        logic ok, nred, cyc_written;
        logic [31:0] old, nv, msk, npc;
        if (rst) begin
            m_ms = 32'h1800; m_mtvec = 32'h100; m_mie = 0; m_mip = 0; m_mscratch = 0;
            m_mepc = 0; m_mcause = 0; m_red = 0; m_rpc = 0; m_cyc = 0;
            return;
        end
        mread(csr_addr, ok, old);
        nred = 1'b0; npc = m_rpc; cyc_written = 1'b0;
        if (cause_set || model_tt()) begin
            if (cause_set) begin
                m_mcause = {28'h0, cause_in};
                if (mepc_set) m_mepc = {exception_intr_address_in, 2'b00};
            end else begin
                m_mcause = 32'h8000_000B;
                m_mepc   = irq_pc & ~32'h3;
            end
            m_ms = (m_ms & ~32'h88) | (m_ms[3] ? 32'h80 : 32'h0);
            nred = 1'b1; npc = m_mtvec;
        end else if (is_mret) begin
            m_ms = (m_ms & ~32'h88) | 32'h80 | (m_ms[7] ? 32'h8 : 32'h0);
            nred = 1'b1; npc = m_mepc;
        end else if (csr_en && csr_op != 2'b00 && ok) begin
            nv  = (csr_op == 2'b01) ? csr_wdata :
                  (csr_op == 2'b10) ? (old | csr_wdata) : (old & ~csr_wdata);
            msk = wmask(csr_addr);
            case (csr_addr)
                12'h300: m_ms       = (m_ms & ~msk) | (nv & msk);
                12'h304: m_mie      = (m_mie & ~msk) | (nv & msk);
                12'h305: m_mtvec    = nv & msk;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc     = nv & msk;
                12'h342: m_mcause   = nv;
                12'hB00: begin m_cyc[31:0] = nv; cyc_written = 1'b1; end
                12'hB80: begin m_cyc[63:32] = nv; cyc_written = 1'b1; end
                default: ;
            endcase
        end
        if (!cyc_written) m_cyc = m_cyc + 64'd1;
        m_mip = ext_irq ? 32'h800 : 32'h0;
        m_red = nred; m_rpc = npc;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; cause_set = v.cs; mepc_set = v.mset; cause_in = v.cause;
        exception_intr_address_in = v.eaddr; is_mret = v.mret; irq_pc = v.irq; ext_irq = v.ext;
        csr_en = v.en; csr_op = v.op; csr_addr = v.caddr; csr_wdata = v.wd; I_or_E = 1'b0;
    endtask

    vec_t tbl[31];
    logic [11:0] addrs[10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                               12'h342, 12'h344, 12'hB00, 12'hB80, 12'h7C0};

    initial begin
        //           rst cs ms ca eaddr     mr irq         ex en op addr     wdata         ck rdata          il tt re rpc
        tbl[0]  = mk(1, 0, 0, 0, 30'h0,   0, 32'h0,     0, 0, 0, 12'h300, 32'h0,        0, 32'h0,         0, 0, 0, 32'h0);
        tbl[1]  = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h300, 32'h0,        1, 32'h1800,      0, 0, 0, 32'h0);
        tbl[2]  = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h305, 32'h0,        1, 32'h100,       0, 0, 0, 32'h0);
        tbl[3]  = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h7C0, 32'h0,        1, 32'h0,         1, 0, 0, 32'h0);
        tbl[4]  = mk(0, 1, 1, 6, 30'h401, 0, 32'h0,     0, 0, 0, 12'h342, 32'h0,        1, 32'h0,         0, 0, 0, 32'h0);
        tbl[5]  = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h341, 32'h0,        1, 32'h1004,      0, 0, 1, 32'h100);
        tbl[6]  = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h342, 32'h0,        1, 32'h6,         0, 0, 0, 32'h100);
        tbl[7]  = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h300, 32'h0,        1, 32'h1800,      0, 0, 0, 32'h100);
        tbl[8]  = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 2, 12'h300, 32'h8,        1, 32'h1800,      0, 0, 0, 32'h100);
        tbl[9]  = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 2, 12'h304, 32'h800,      1, 32'h0,         0, 0, 0, 32'h100);
        tbl[10] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     1, 1, 0, 12'h304, 32'h0,        1, 32'h800,       0, 0, 0, 32'h100);
        tbl[11] = mk(0, 0, 0, 0, 30'h0,   0, 32'h2002,  1, 1, 0, 12'h344, 32'h0,        1, 32'h800,       0, 1, 0, 32'h100);
        tbl[12] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h342, 32'h0,        1, 32'h8000_000B, 0, 0, 1, 32'h100);
        tbl[13] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h341, 32'h0,        1, 32'h2000,      0, 0, 0, 32'h100);
        tbl[14] = mk(0, 0, 0, 0, 30'h0,   1, 32'h0,     0, 1, 0, 12'h300, 32'h0,        1, 32'h1880,      0, 0, 0, 32'h100);
        tbl[15] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h300, 32'h0,        1, 32'h1888,      0, 0, 1, 32'h2000);
        tbl[16] = mk(0, 1, 0, 2, 30'h0,   0, 32'h0,     0, 1, 1, 12'h340, 32'hDEADBEEF, 1, 32'h0,         0, 0, 0, 32'h2000);
        tbl[17] = mk(0, 1, 1, 3, 30'h123, 0, 32'h0,     0, 1, 0, 12'h340, 32'h0,        1, 32'h0,         0, 0, 1, 32'h100);
        tbl[18] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h342, 32'h0,        1, 32'h3,         0, 0, 1, 32'h100);
        tbl[19] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h341, 32'h0,        1, 32'h48C,       0, 0, 0, 32'h100);
        tbl[20] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 1, 12'h344, 32'hFFFFFFFF, 1, 32'h0,         0, 0, 0, 32'h100);
        tbl[21] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h344, 32'h0,        1, 32'h0,         0, 0, 0, 32'h100);
        tbl[22] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 1, 12'h305, 32'h203,      1, 32'h100,       0, 0, 0, 32'h100);
        tbl[23] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h305, 32'h0,        1, 32'h200,       0, 0, 0, 32'h100);
        tbl[24] = mk(0, 1, 0, 1, 30'h0,   0, 32'h0,     0, 1, 0, 12'h305, 32'h0,        1, 32'h200,       0, 0, 0, 32'h100);
        tbl[25] = mk(1, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h305, 32'h0,        1, 32'h200,       0, 0, 1, 32'h200);
        tbl[26] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h305, 32'h0,        1, 32'h100,       0, 0, 0, 32'h0);
`ifdef CSR_MCYCLE_EN
        tbl[27] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 1, 12'hB00, 32'hFFFFFFFF, 1, 32'h1,         0, 0, 0, 32'h0);
        tbl[28] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'hB00, 32'h0,        1, 32'hFFFFFFFF,  0, 0, 0, 32'h0);
        tbl[29] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'hB80, 32'h0,        1, 32'h1,         0, 0, 0, 32'h0);
        tbl[30] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'hB00, 32'h0,        1, 32'h1,         0, 0, 0, 32'h0);
`else
        tbl[27] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 1, 12'hB00, 32'hFFFFFFFF, 1, 32'h0,         1, 0, 0, 32'h0);
        tbl[28] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'hB80, 32'h0,        1, 32'h0,         1, 0, 0, 32'h0);
        tbl[29] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h300, 32'h0,        1, 32'h1800,      0, 0, 0, 32'h0);
        tbl[30] = mk(0, 0, 0, 0, 30'h0,   0, 32'h0,     0, 1, 0, 12'h305, 32'h0,        1, 32'h100,       0, 0, 0, 32'h0);
`endif

        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            if (tbl[i].chk) begin
                check($sformatf("v%0d rdata", i),    csr_rdata,   tbl[i].e_rd);
                check($sformatf("v%0d illegal", i),  {31'b0, csr_illegal}, {31'b0, tbl[i].e_ill});
                check($sformatf("v%0d take_trap", i), {31'b0, Take_trap},  {31'b0, tbl[i].e_tt});
                check($sformatf("v%0d redirect", i), {31'b0, redirect},    {31'b0, tbl[i].e_red});
                check($sformatf("v%0d redirect_pc", i), redirect_pc, tbl[i].e_rpc);
            end
            @(posedge clk);
            model_step();
        end

        for (int n = 0; n < 600; n++) begin
            vec_t v;
            logic ok;
            logic [31:0] er;
            @(negedge clk);
            v.rst   = ($urandom_range(0, 63) == 0);
            v.cs    = ($urandom_range(0, 7) == 0);
            v.mset  = 1'($urandom);
            v.cause = 4'($urandom);
            v.eaddr = 30'($urandom);
            v.mret  = ($urandom_range(0, 7) == 0);
            v.irq   = $urandom;
            v.ext   = 1'($urandom);
            v.en    = 1'($urandom);
            v.op    = 2'($urandom);
            v.caddr = ($urandom_range(0, 15) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 9)];
            v.wd    = $urandom;
            drive(v);
            #1;
            mread(csr_addr, ok, er);
            check("rnd rdata", csr_rdata, er);
            check("rnd illegal", {31'b0, csr_illegal}, {31'b0, csr_en & ~ok});
            check("rnd take_trap", {31'b0, Take_trap}, {31'b0, model_tt()});
            check("rnd redirect", {31'b0, redirect}, {31'b0, m_red});
            check("rnd redirect_pc", redirect_pc, m_rpc);
            @(posedge clk);
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
